// File: rtl/mem_access_unit.sv
// Load/store unit for a 16-bit word, byte-addressed, big-endian data memory.
// Byte stores run as a read phase followed by a merged write phase.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_wr,
  input  logic                  req_byte,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [15:0]           resp_rdata,
  output logic                  err_align,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata
);

  typedef enum logic {IDLE, BST_WR} state_t;

  state_t                state;
  logic [15:0]           merge_q;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [7:0]            hold_byte;

  logic                  accept;
  logic                  misaligned;
  logic [ADDR_WIDTH-1:0] req_word_addr;
  logic [7:0]            load_byte;
  logic [15:0]           load_ext;
  logic [15:0]           merged;

  assign req_ready     = (state == IDLE) & ~rst;
  assign accept        = req_valid & req_ready;
  assign misaligned    = ~req_byte & req_addr[0];
  assign req_word_addr = {req_addr[ADDR_WIDTH-1:1], 1'b0};

  // Even byte address lives in the upper lane.
  assign load_byte = req_addr[0] ? mem_rdata[7:0] : mem_rdata[15:8];
  assign load_ext  = {{8{req_signed & load_byte[7]}}, load_byte};
  assign merged    = hold_addr[0] ? {merge_q[15:8], hold_byte}
                                  : {hold_byte, merge_q[7:0]};

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (!rst) begin
      if (state == BST_WR) begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = {hold_addr[ADDR_WIDTH-1:1], 1'b0};
        mem_wdata  = merged;
      end else if (req_valid && !misaligned) begin
        mem_enable = 1'b1;
        mem_addr   = req_word_addr;
        // Byte stores only read here; the write happens in BST_WR.
        if (req_wr && !req_byte) begin
          mem_wr    = 1'b1;
          mem_wdata = req_wdata;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      err_align  <= 1'b0;
      merge_q    <= '0;
      hold_addr  <= '0;
      hold_byte  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (misaligned) begin
              resp_valid <= 1'b1;
              err_align  <= 1'b1;
              resp_rdata <= '0;
            end else if (req_wr && req_byte) begin
              merge_q   <= mem_rdata;
              hold_addr <= req_addr;
              hold_byte <= req_wdata[7:0];
              state     <= BST_WR;
            end else begin
              resp_valid <= 1'b1;
              err_align  <= 1'b0;
              if (req_wr)
                resp_rdata <= '0;
              else if (req_byte)
                resp_rdata <= load_ext;
              else
                resp_rdata <= mem_rdata;
            end
          end
        end
        BST_WR: begin
          resp_valid <= 1'b1;
          err_align  <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized traffic
// checked against a word-array reference model of the memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wr, req_byte, req_signed;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, err_align;
  logic [15:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_enable, mem_wr;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_byte(req_byte),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .err_align(err_align), .mem_addr(mem_addr), .mem_enable(mem_enable),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr[8:1]];
  always @(posedge clk) if (mem_enable && mem_wr) mem[mem_addr[8:1]] <= mem_wdata;

  // Drives one request from a falling edge and returns what was observed.
  // lat = falling edges from acceptance to resp_valid, -1 if nothing came.
  task automatic run_req(input logic wr, input logic byt, input logic sgn,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         output int lat, output logic [15:0] rdata,
                         output logic err, output logic saw_en,
                         output logic ready_after);
    bit acc = 0;
    req_wr = wr; req_byte = byt; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    lat = -1; rdata = 'x; err = 'x; saw_en = 1'b0; ready_after = 1'bx;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (req_ready) begin acc = 1; saw_en = mem_enable; break; end
      @(negedge clk);
    end
    if (!acc) begin req_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    ready_after = req_ready;
    for (int k = 1; k <= 5; k++) begin
      saw_en = saw_en | mem_enable;
      if (resp_valid) begin lat = k; rdata = resp_rdata; err = err_align; break; end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_wr = 0; req_byte = 0; req_signed = 0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({resp_valid, resp_rdata, err_align, req_ready, mem_enable, mem_wr} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rv=%b rd=%h err=%b rdy=%b en=%b wr=%b, want all 0",
               resp_valid, resp_rdata, err_align, req_ready, mem_enable, mem_wr);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || mem_enable !== 1'b0 || mem_addr !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_release: got rdy=%b en=%b addr=%h, want rdy=1 en=0 addr=0",
               req_ready, mem_enable, mem_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_word();
    int lat; logic [15:0] rd; logic er, se, ra;
    run_req(1, 0, 0, 16'h0010, 16'hBEEF, lat, rd, er, se, ra);
    vectors++;
    if (lat !== 1 || rd !== 16'h0 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL word_store: got lat=%0d rd=%h err=%b, want lat=1 rd=0000 err=0", lat, rd, er);
    end
    run_req(0, 0, 0, 16'h0010, 16'h0, lat, rd, er, se, ra);
    vectors++;
    if (lat !== 1 || rd !== 16'hBEEF || er !== 1'b0) begin
      miscompares++;
      $display("FAIL word_load: got lat=%0d rd=%h err=%b, want lat=1 rd=beef err=0", lat, rd, er);
    end
  endtask

  task automatic test_byte_store();
    int lat; logic [15:0] rd; logic er, se, ra;
    run_req(1, 0, 0, 16'h0010, 16'h1234, lat, rd, er, se, ra);
    run_req(1, 1, 0, 16'h0011, 16'h007A, lat, rd, er, se, ra);
    vectors++;
    if (lat !== 2 || ra !== 1'b0 || er !== 1'b0 || rd !== 16'h0) begin
      miscompares++;
      $display("FAIL bst_odd_timing: got lat=%0d ready_mid=%b err=%b rd=%h, want 2 0 0 0000",
               lat, ra, er, rd);
    end
    run_req(0, 0, 0, 16'h0010, 16'h0, lat, rd, er, se, ra);
    vectors++;
    if (rd !== 16'h127A) begin
      miscompares++;
      $display("FAIL bst_odd_data: got %h, want 127a", rd);
    end
    run_req(1, 0, 0, 16'h0010, 16'h1234, lat, rd, er, se, ra);
    run_req(1, 1, 0, 16'h0010, 16'hFF7A, lat, rd, er, se, ra);
    run_req(0, 0, 0, 16'h0010, 16'h0, lat, rd, er, se, ra);
    vectors++;
    if (rd !== 16'h7A34) begin
      miscompares++;
      $display("FAIL bst_even_data: got %h, want 7a34", rd);
    end
  endtask

  task automatic test_byte_load();
    int lat; logic [15:0] rd; logic er, se, ra;
    logic [16:0] cases [3];
    logic [15:0] want [3];
    cases[0] = {1'b1, 16'h0020}; want[0] = 16'hFF80;
    cases[1] = {1'b0, 16'h0020}; want[1] = 16'h0080;
    cases[2] = {1'b1, 16'h0021}; want[2] = 16'hFFC3;
    run_req(1, 0, 0, 16'h0020, 16'h80C3, lat, rd, er, se, ra);
    for (int i = 0; i < 3; i++) begin
      run_req(0, 1, cases[i][16], cases[i][15:0], 16'h0, lat, rd, er, se, ra);
      vectors++;
      if (lat !== 1 || rd !== want[i] || er !== 1'b0) begin
        miscompares++;
        $display("FAIL byte_load_%0d: got lat=%0d rd=%h err=%b, want lat=1 rd=%h err=0",
                 i, lat, rd, er, want[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [15:0] rd; logic er, se, ra;
    run_req(0, 0, 0, 16'h0013, 16'h0, lat, rd, er, se, ra);
    vectors++;
    if (se !== 1'b0 || lat !== 1 || er !== 1'b1 || rd !== 16'h0) begin
      miscompares++;
      $display("FAIL misaligned_word: got en_seen=%b lat=%0d err=%b rd=%h, want 0 1 1 0000",
               se, lat, er, rd);
    end
    run_req(0, 1, 0, 16'h0013, 16'h0, lat, rd, er, se, ra);
    vectors++;
    if (lat !== 1 || er !== 1'b0 || se !== 1'b1) begin
      miscompares++;
      $display("FAIL odd_byte_load: got lat=%0d err=%b en_seen=%b, want 1 0 1", lat, er, se);
    end
  endtask

  task automatic test_reset_bst();
    int lat; logic [15:0] rd; logic er, se, ra;
    logic wr_seen;
    run_req(1, 0, 0, 16'h0030, 16'h1234, lat, rd, er, se, ra);
    req_wr = 1; req_byte = 1; req_signed = 0; req_addr = 16'h0031; req_wdata = 16'h0055;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    wr_seen = mem_wr | mem_enable;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (wr_seen !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 16'h0 || err_align !== 1'b0 ||
        req_ready !== 1'b0 || mem_enable !== 1'b0 || mem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_in_bst: got wr_seen=%b rv=%b rd=%h err=%b rdy=%b en=%b wr=%b, want all 0",
               wr_seen, resp_valid, resp_rdata, err_align, req_ready, mem_enable, mem_wr);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_release_ready: got %b, want 1", req_ready);
    end
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0 || mem[8'h18] !== 16'h1234) begin
      miscompares++;
      $display("FAIL rst_abandon: got rv=%b word=%h, want rv=0 word=1234", resp_valid, mem[8'h18]);
    end
    run_req(0, 0, 0, 16'h0030, 16'h0, lat, rd, er, se, ra);
    vectors++;
    if (rd !== 16'h1234) begin
      miscompares++;
      $display("FAIL rst_abandon_load: got %h, want 1234", rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] rd; logic er, se, ra;
    logic [15:0] vals [4];
    for (int i = 0; i < 4; i++) begin
      vals[i] = 16'($urandom);
      run_req(1, 0, 0, 16'(2 * i), vals[i], lat, rd, er, se, ra);
    end
    req_wr = 0; req_byte = 0; req_signed = 0; req_addr = 16'h0000; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready_%0d: got %b, want 1", i, req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      if (i < 3) req_addr = 16'(2 * (i + 1)); else req_valid = 1'b0;
      vectors++;
      if (resp_valid !== 1'b1 || resp_rdata !== vals[i] || err_align !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_resp_%0d: got rv=%b rd=%h err=%b, want rv=1 rd=%h err=0",
                 i, resp_valid, resp_rdata, err_align, vals[i]);
      end
    end
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_tail: got rv=%b, want 0", resp_valid);
    end
  endtask

  task automatic test_random();
    int lat, exp_lat; logic [15:0] rd, exp_rd, word; logic er, exp_er, se, ra;
    logic wr, byt, sgn; logic [15:0] addr, wdata; logic [7:0] b;
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom); byt = 1'($urandom); sgn = 1'($urandom);
      addr = 16'h0040 + 16'($urandom_range(0, 31));
      wdata = 16'($urandom);
      word = ref_mem[addr[8:1]];
      exp_lat = 1; exp_rd = 16'h0; exp_er = 1'b0;
      if (!byt && addr[0]) begin
        exp_er = 1'b1;
      end else if (wr && byt) begin
        exp_lat = 2;
        if (addr[0]) ref_mem[addr[8:1]] = {word[15:8], wdata[7:0]};
        else         ref_mem[addr[8:1]] = {wdata[7:0], word[7:0]};
      end else if (wr) begin
        ref_mem[addr[8:1]] = wdata;
      end else if (byt) begin
        b = addr[0] ? word[7:0] : word[15:8];
        exp_rd = sgn ? 16'(signed'(b)) : {8'h00, b};
      end else begin
        exp_rd = word;
      end
      run_req(wr, byt, sgn, addr, wdata, lat, rd, er, se, ra);
      vectors++;
      if (lat !== exp_lat || rd !== exp_rd || er !== exp_er) begin
        miscompares++;
        $display("FAIL rand_%0d wr=%b byte=%b sgn=%b addr=%h: got lat=%0d rd=%h err=%b, want lat=%0d rd=%h err=%b",
                 i, wr, byt, sgn, addr, lat, rd, er, exp_lat, exp_rd, exp_er);
      end
    end
    for (int w = 8'h20; w < 8'h30; w++) begin
      vectors++;
      if (mem[w] !== ref_mem[w]) begin
        miscompares++;
        $display("FAIL rand_mem word %h: got %h, want %h", w * 2, mem[w], ref_mem[w]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 16'h0; ref_mem[i] = 16'h0; end
    @(negedge clk);
    test_reset();
    test_word();
    test_byte_store();
    test_byte_load();
    test_misaligned();
    test_reset_bst();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side load/store unit that drives the 16-bit word-wide, byte-addressed data memory on behalf of the pipeline's memory stage. It accepts word and byte load/store requests, enforces alignment, and performs sign or zero extension for byte loads. Byte stores are done as a two-cycle read-modify-write, because the memory does not allow a concurrent read and write. It sits between the execute/memory pipeline registers and the data memory port.

## Interface
- ADDR_WIDTH, 16, byte-address width; must match the memory's address width.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present; requester holds all req_* stable until accepted.
- req_wr  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_signed  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  16  store data; byte stores use [7:0].
- req_ready  out  1  unit can accept a request this cycle.
- resp_valid  out  1  one-cycle pulse; the request has completed.
- resp_rdata  out  16  load result; 0 for stores and errors.
- err_align  out  1  valid with resp_valid; word access to an odd address.
- mem_addr  out  ADDR_WIDTH  memory address; bit 0 always 0.
- mem_enable  out  1  memory enable.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data; combinational, zero-delay.

## Operation
- Byte lanes are big-endian: even byte address is mem word bits [15:8], odd byte address is bits [7:0].
- Acceptance occurs when req_valid & req_ready is sampled at a rising edge.
- req_ready = (state == IDLE) & ~rst.
- States: IDLE, BST_WR.
- IDLE with no request:
  - mem_enable = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0.
- IDLE, word access with req_addr[0] = 1:
  - No memory access; mem_enable stays 0.
  - Next cycle: resp_valid = 1, err_align = 1, resp_rdata = 0.
- IDLE, word load:
  - mem_enable = 1, mem_wr = 0, mem_addr = {req_addr[ADDR_WIDTH-1:1], 0}.
  - resp_rdata is registered from mem_rdata at the acceptance edge.
- IDLE, word store:
  - mem_enable = 1, mem_wr = 1, mem_wdata = req_wdata.
  - The memory writes at the acceptance edge.
- IDLE, byte load:
  - Read as for a word load, then select the byte lane by req_addr[0].
  - Extend to 16 bits per req_signed and register the result.
- IDLE, byte store (read phase):
  - Read the word (mem_wr = 0).
  - At the acceptance edge, capture mem_rdata into merge_q, and req_addr, req_wdata[7:0] into holding registers.
  - Go to BST_WR.
- BST_WR (write phase):
  - mem_enable = 1, mem_wr = 1, mem_addr = held word address.
  - mem_wdata = merge_q with the selected lane replaced by the held byte; the other lane is preserved.
  - Return to IDLE at the next edge.
- Every completion pulses resp_valid for exactly one cycle. There is no response backpressure.
- err_align is 0 on every non-error response.
- Reset, with priority over all activity:
  - State goes to IDLE; resp_valid, resp_rdata, err_align and all holding registers go to 0.
  - mem_enable and mem_wr are forced to 0 while rst is high.
  - A byte store caught in BST_WR is abandoned: no write and no response.

## Timing
- Word load, word store, byte load, and misaligned-word error: accepted at edge N, resp_valid high during cycle N+1.
- Byte store: accepted at edge N, memory write at edge N+1, resp_valid high during cycle N+2. req_ready is low during cycle N+1.
- Throughput:
  - One word access or byte load per cycle, back-to-back.
  - A byte store occupies 2 cycles.
  - A new request may be accepted in the same cycle resp_valid is high for the previous one.
- mem_* outputs are combinational from state and req_* in IDLE, and from registers in BST_WR.
- Request inputs are ignored while req_ready = 0.

## Test plan
- Word store 0xBEEF @0x0010, then word load @0x0010: resp_valid 1 cycle after each acceptance; load resp_rdata = 0xBEEF, err_align = 0.
- Word 0x1234 @0x0010, byte store 0x7A @0x0011: req_ready low for 1 cycle, resp_valid 2 cycles after acceptance, memory word becomes 0x127A. Byte store 0x7A @0x0010 instead gives 0x7A34.
- Word 0x80C3 @0x0020: signed byte load @0x0020 returns 0xFF80; unsigned returns 0x0080; signed @0x0021 returns 0xFFC3.
- Word load @0x0013: mem_enable never asserts, resp_valid = 1, err_align = 1, resp_rdata = 0 next cycle. Byte load @0x0013 is legal (err_align = 0).
- rst asserted during BST_WR of a byte store: no mem_wr pulse, memory word unchanged, no resp_valid. Cycle after rst: all outputs 0, req_ready = 1 once rst drops.
- Four back-to-back word loads @0x0000/2/4/6 with req_valid held high: four consecutive resp_valid cycles, data in order, req_ready never low.
